pwm_deadtime: RTL

- Downstream stage of the APB4 PWM timer; consumes its per-channel pwm_o outputs.
- Per channel, produces a complementary high-side/low-side drive pair with programmable dead time inserted on every transition.
- Absorbs input pulses narrower than the dead time and flags each absorbed pulse.
- Sits between the PWM core and the pad/gate-driver ring, in the same clock domain as the APB4 register file.

---
 rtl/pwm_deadtime_pkg.sv | 24 ++
 rtl/pwm_dt_chnl.sv | 108 ++++++++++
 rtl/pwm_deadtime.sv | 61 ++++++
 3 files changed

// File: rtl/pwm_deadtime_pkg.sv
// Shared widths and the per-channel state encoding for the PWM dead-time stage.
package pwm_deadtime_pkg;

   localparam int PWM_DT_WIDTH    = 8;
   localparam int PWM_DT_CHNL_NUM = 4;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_LOW   = 3'd1,
      ST_DT_LH = 3'd2,
      ST_HIGH  = 3'd3,
      ST_DT_HL = 3'd4
   } dt_state_e;

   // {high, low} drive implied by a state; OFF and both dead phases drive neither side.
   function automatic logic [1:0] state_drive(input dt_state_e s);
      case (s)
         ST_LOW:  return 2'b01;
         ST_HIGH: return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/pwm_dt_chnl.sv
// Single channel: complementary drive FSM, dead-time counter and registered outputs.
module pwm_dt_chnl
   import pwm_deadtime_pkg::*;
#(
   parameter int DT_WIDTH = PWM_DT_WIDTH
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                en_i,
   input  logic [DT_WIDTH-1:0] dt_i,
   input  logic                pwm_i,
   output logic                pwmh_o,
   output logic                pwml_o,
   output logic                drop_o
);

   dt_state_e           state_q, state_d;
   logic [DT_WIDTH-1:0] cnt_q, cnt_d;
   logic                pwmh_q, pwmh_d;
   logic                pwml_q, pwml_d;
   logic                drop_q, drop_d;
   logic                dt_zero;

   assign dt_zero = (dt_i == '0);

   always_comb begin
      // NOTE: every target is defaulted first so no branch can leave one unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      drop_d  = 1'b0;
      if (!en_i) begin
         state_d = ST_OFF;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               cnt_d = dt_i;
               if (pwm_i) state_d = dt_zero ? ST_HIGH : ST_DT_LH;
               else       state_d = dt_zero ? ST_LOW  : ST_DT_HL;
            end
            ST_LOW: begin
               if (pwm_i) begin
                  cnt_d   = dt_i;
                  state_d = dt_zero ? ST_HIGH : ST_DT_LH;
               end
            end
            ST_HIGH: begin
               if (!pwm_i) begin
                  cnt_d   = dt_i;
                  state_d = dt_zero ? ST_LOW : ST_DT_HL;
               end
            end
            // A dead phase whose input reverts is a pulse shorter than dt: fall back and flag it.
            ST_DT_LH: begin
               if (!pwm_i) begin
                  state_d = ST_LOW;
                  cnt_d   = '0;
                  drop_d  = 1'b1;
               end else if (cnt_q <= DT_WIDTH'(1)) begin
                  state_d = ST_HIGH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - DT_WIDTH'(1);
               end
            end
            ST_DT_HL: begin
               if (pwm_i) begin
                  state_d = ST_HIGH;
                  cnt_d   = '0;
                  drop_d  = 1'b1;
               end else if (cnt_q <= DT_WIDTH'(1)) begin
                  state_d = ST_LOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - DT_WIDTH'(1);
               end
            end
            default: begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end
         endcase
      end
      {pwmh_d, pwml_d} = state_drive(state_d);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         pwmh_q  <= 1'b0;
         pwml_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pwmh_q  <= pwmh_d;
         pwml_q  <= pwml_d;
         drop_q  <= drop_d;
      end
   end

   assign pwmh_o = pwmh_q;
   assign pwml_o = pwml_q;
   assign drop_o = drop_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Multi-channel complementary PWM drive with dead-time insertion and short-pulse absorption.
// Define PWM_DT_SYNC_EN to pass each pwm_i bit through a 2-flop synchronizer first.
module pwm_deadtime
   import pwm_deadtime_pkg::*;
#(
   parameter int CHNL_NUM = PWM_DT_CHNL_NUM,
   parameter int DT_WIDTH = PWM_DT_WIDTH
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                en_i,
   input  logic [DT_WIDTH-1:0] dt_i,
   input  logic [CHNL_NUM-1:0] pwm_i,
   output logic [CHNL_NUM-1:0] pwmh_o,
   output logic [CHNL_NUM-1:0] pwml_o,
   output logic [CHNL_NUM-1:0] drop_o
);

   logic [CHNL_NUM-1:0] pwm_s;

`ifdef PWM_DT_SYNC_EN
   // pwm_i comes from the divided timer clock here, so resynchronize before the FSMs.
   logic [CHNL_NUM-1:0] sync1_q, sync1_d;
   logic [CHNL_NUM-1:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = pwm_i;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign pwm_s = sync2_q;
`else
   assign pwm_s = pwm_i;
`endif

   for (genvar g = 0; g < CHNL_NUM; g++) begin : g_chnl
      pwm_dt_chnl #(
         .DT_WIDTH (DT_WIDTH)
      ) u_chnl (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .en_i    (en_i),
         .dt_i    (dt_i),
         .pwm_i   (pwm_s[g]),
         .pwmh_o  (pwmh_o[g]),
         .pwml_o  (pwml_o[g]),
         .drop_o  (drop_o[g])
      );
   end

endmodule
